// File: rtl/rotator_gen_if.sv
// Handshake bundle between a twiddle consumer (master) and rotator_gen (slave).
// W must match the W of the rotator_gen instance it connects to.
interface rotator_gen_if #(
  parameter int W = 18
) ();
  logic                start;
  logic [3:0]          stage;
  logic                inv;
  logic                rot_ready;
  logic                rot_valid;
  logic signed [W-1:0] rotator_real;
  logic signed [W-1:0] rotator_img;
  logic                rot_last;
  logic                busy;
  logic                done;

  modport master (
    output start, stage, inv, rot_ready,
    input  rot_valid, rotator_real, rotator_img, rot_last, busy, done
  );

  modport slave (
    input  start, stage, inv, rot_ready,
    output rot_valid, rotator_real, rotator_img, rot_last, busy, done
  );
endinterface

// File: rtl/rotator_gen.sv
// Radix-2 DIF twiddle generator: per-stage sequence of e^(-j*2*pi*k/N) built from
// a quarter-wave cosine table, three-stage pipeline with valid/ready output.
module rotator_gen #(
  parameter int LOG2N = 6,
  parameter int W     = 18
) (
  input logic          clk,
  input logic          rst,
  rotator_gen_if.slave io
);
  localparam int  N   = 1 << LOG2N;
  localparam int  Q   = N / 4;
  localparam int  JW  = LOG2N - 1;
  localparam int  RW  = LOG2N - 2;
  localparam real PI  = 3.14159265358979323846;
  localparam real AMP = 2.0 ** (W - 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  // NOTE: the table is elaboration-time constants driven onto wires, not a
  // storage array, so it has no reset and costs no flops.
  logic signed [W-1:0] w_rom [0:Q];
  for (genvar g = 0; g <= Q; g++) begin : g_rom
    localparam int VAL = $rtoi(AMP * $cos(2.0 * PI * real'(g) / real'(N)) + 0.5);
    assign w_rom[g] = W'(VAL);
  end

  state_t              r_state;
  state_t              w_next;
  logic [JW-1:0]       r_j;
  logic [3:0]          r_stage;
  logic                r_inv;

  logic                w_en;
  logic                w_busy;
  logic                w_accept;
  logic                w_issue;
  logic [3:0]          w_stage_in;
  logic [3:0]          w_stage_cur;
  logic [JW-1:0]       w_j_cur;
  logic [JW-1:0]       w_mask;
  logic [LOG2N-1:0]    w_k;
  logic                w_last_issue;

  logic                r_s1_valid;
  logic                r_s1_last;
  logic [1:0]          r_s1_quad;
  logic [RW-1:0]       r_s1_r;
  logic                r_s2_valid;
  logic                r_s2_last;
  logic [1:0]          r_s2_quad;
  logic signed [W-1:0] r_s2_ca;
  logic signed [W-1:0] r_s2_cb;
  logic                r_valid;
  logic                r_last;
  logic                r_done;
  logic signed [W-1:0] r_real;
  logic signed [W-1:0] r_img;

  logic [RW:0]         w_idx_b;
  logic signed [W-1:0] w_re;
  logic signed [W-1:0] w_sin;
  logic signed [W-1:0] w_im;

  assign w_en = !r_valid || io.rot_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (io.start) w_next = S_RUN;
      S_RUN:   if (w_en && (r_j == {JW{1'b1}})) w_next = S_FLUSH;
      S_FLUSH: if (r_valid && io.rot_ready && r_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state != S_IDLE);
    w_accept = (r_state == S_IDLE) && io.start;
    w_issue  = w_accept || ((r_state == S_RUN) && w_en);
  end

  // j = 0 is issued in the start cycle itself, using the live stage input.
  always_comb begin
    w_stage_in   = (io.stage >= 4'(LOG2N)) ? 4'(LOG2N - 1) : io.stage;
    w_stage_cur  = w_accept ? w_stage_in : r_stage;
    w_j_cur      = w_accept ? '0 : r_j;
    w_mask       = {JW{1'b1}} >> w_stage_cur;
    w_k          = {1'b0, w_j_cur & w_mask} << w_stage_cur;
    w_last_issue = (w_j_cur == {JW{1'b1}});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_j     <= '0;
      r_stage <= '0;
      r_inv   <= 1'b0;
    end else if (w_accept) begin
      r_j     <= JW'(1);
      r_stage <= w_stage_in;
      r_inv   <= io.inv;
    end else if ((r_state == S_RUN) && w_en) begin
      r_j     <= r_j + JW'(1);
    end
  end

  assign w_idx_b = (RW + 1)'(Q) - {1'b0, r_s1_r};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_quad  <= '0;
      r_s1_r     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_quad  <= '0;
      r_s2_ca    <= '0;
      r_s2_cb    <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_real     <= '0;
      r_img      <= '0;
    end else if (w_en) begin
      r_s1_valid <= w_issue;
      r_s1_last  <= w_issue && w_last_issue;
      r_s1_quad  <= w_k[LOG2N-1 -: 2];
      r_s1_r     <= w_k[RW-1:0];
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s2_quad  <= r_s1_quad;
      r_s2_ca    <= w_rom[{1'b0, r_s1_r}];
      r_s2_cb    <= w_rom[w_idx_b];
      r_valid    <= r_s2_valid;
      r_last     <= r_s2_last;
      r_real     <= w_re;
      r_img      <= w_im;
    end
  end

  // ca = C[r] = cos(phi), cb = C[N/4-r] = sin(phi); rotate by the quadrant.
  always_comb begin
    w_re  = r_s2_ca;
    w_sin = r_s2_cb;
    case (r_s2_quad)
      2'd1: begin w_re = -r_s2_cb; w_sin =  r_s2_ca; end
      2'd2: begin w_re = -r_s2_ca; w_sin = -r_s2_cb; end
      2'd3: begin w_re =  r_s2_cb; w_sin = -r_s2_ca; end
      default: ;
    endcase
    w_im = r_inv ? w_sin : -w_sin;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_done <= 1'b0;
    else      r_done <= r_valid && io.rot_ready && r_last;
  end

  assign io.rot_valid    = r_valid;
  assign io.rot_last     = r_last;
  assign io.rotator_real = r_real;
  assign io.rotator_img  = r_img;
  assign io.busy         = w_busy;
  assign io.done         = r_done;
endmodule

// File: tb/tb_rotator_gen.sv
// Scoreboard bench for rotator_gen: an N=8 instance for directed hand-computed
// sequences and an N=64 instance checked against a floating-point model.
module tb_rotator_gen;
  localparam int W = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rotator_gen_if #(.W(W)) bus3 ();
  rotator_gen_if #(.W(W)) bus6 ();

  rotator_gen #(.LOG2N(3), .W(W)) dut3 (.clk(clk), .rst(rst), .io(bus3));
  rotator_gen #(.LOG2N(6), .W(W)) dut6 (.clk(clk), .rst(rst), .io(bus6));

  typedef struct {
    int re;
    int im;
    bit last;
  } tw_t;

  tw_t q3[$];
  tw_t q6[$];
  int  errors = 0;
  int  checks = 0;

  int re8[4] = '{65536, 46341, 0, -46341};
  int im8[4] = '{0, -46341, -65536, -46341};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  task automatic push3(input int s, input bit inv);
    int se;
    int k;
    tw_t t;
    se = (s >= 3) ? 2 : s;
    for (int j = 0; j < 4; j++) begin
      k      = (j % (8 >> (se + 1))) << se;
      t.re   = re8[k];
      t.im   = inv ? -im8[k] : im8[k];
      t.last = (j == 3);
      q3.push_back(t);
    end
  endtask

  task automatic push6();
    real ang;
    tw_t t;
    for (int j = 0; j < 32; j++) begin
      ang    = 2.0 * 3.14159265358979323846 * real'(j) / 64.0;
      t.re   = rnd(65536.0 * $cos(ang));
      t.im   = -rnd(65536.0 * $sin(ang));
      t.last = (j == 31);
      q6.push_back(t);
    end
  endtask

  task automatic start3(input int s, input bit inv);
    bus3.stage = 4'(s);
    bus3.inv   = inv;
    bus3.start = 1'b1;
    @(posedge clk); #1;
    bus3.start = 1'b0;
  endtask

  task automatic drain3();
    int n = 0;
    while ((q3.size() != 0 || bus3.busy) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      errors++;
      checks++;
      $display("FAIL drain3: timeout, %0d twiddles outstanding", q3.size());
    end
    check("idle_valid3", int'(bus3.rot_valid), 0);
  endtask

  // Monitor for the N=8 instance: scoreboard, hold-under-stall, done pulse.
  tw_t m3;
  int  h_re, h_im, h_last;
  bit  stall3 = 1'b0;
  bit  lastx3 = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      stall3 = 1'b0;
      lastx3 = 1'b0;
    end else begin
      check("done3", int'(bus3.done), int'(lastx3));
      if (stall3) begin
        check("hold_valid3", int'(bus3.rot_valid), 1);
        check("hold_real3", int'($signed(bus3.rotator_real)), h_re);
        check("hold_img3", int'($signed(bus3.rotator_img)), h_im);
        check("hold_last3", int'(bus3.rot_last), h_last);
      end
      stall3 = 1'b0;
      lastx3 = 1'b0;
      if (bus3.rot_valid && bus3.rot_ready) begin
        if (q3.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected3: got twiddle (%0d,%0d), expected none",
                   $signed(bus3.rotator_real), $signed(bus3.rotator_img));
        end else begin
          m3 = q3.pop_front();
          check("real3", int'($signed(bus3.rotator_real)), m3.re);
          check("img3", int'($signed(bus3.rotator_img)), m3.im);
          check("last3", int'(bus3.rot_last), int'(m3.last));
        end
        lastx3 = bus3.rot_last;
      end else if (bus3.rot_valid) begin
        stall3 = 1'b1;
        h_re   = int'($signed(bus3.rotator_real));
        h_im   = int'($signed(bus3.rotator_img));
        h_last = int'(bus3.rot_last);
      end
    end
  end

  // Monitor for the N=64 instance against the floating-point model.
  tw_t m6;
  bit  lastx6 = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      lastx6 = 1'b0;
    end else begin
      check("done6", int'(bus6.done), int'(lastx6));
      lastx6 = 1'b0;
      if (bus6.rot_valid && bus6.rot_ready) begin
        if (q6.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected6: got twiddle (%0d,%0d), expected none",
                   $signed(bus6.rotator_real), $signed(bus6.rotator_img));
        end else begin
          m6 = q6.pop_front();
          check("real6", int'($signed(bus6.rotator_real)), m6.re);
          check("img6", int'($signed(bus6.rotator_img)), m6.im);
          check("last6", int'(bus6.rot_last), int'(m6.last));
        end
        lastx6 = bus6.rot_last;
      end
    end
  end

  int st_tab[4] = '{1, 2, 7, 0};
  bit iv_tab[4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int n;
    bus3.start = 1'b0; bus3.stage = '0; bus3.inv = 1'b0; bus3.rot_ready = 1'b1;
    bus6.start = 1'b0; bus6.stage = '0; bus6.inv = 1'b0; bus6.rot_ready = 1'b1;

    #1 rst = 1'b0;
    #2;
    check("rst_valid", int'(bus3.rot_valid), 0);
    check("rst_last", int'(bus3.rot_last), 0);
    check("rst_busy", int'(bus3.busy), 0);
    check("rst_done", int'(bus3.done), 0);
    check("rst_real", int'($signed(bus3.rotator_real)), 0);
    check("rst_img", int'($signed(bus3.rotator_img)), 0);
    check("rst_valid6", int'(bus6.rot_valid), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // N=64, stage 0: 32 twiddles against the model
    push6();
    bus6.stage = 4'd0;
    bus6.start = 1'b1;
    @(posedge clk); #1;
    bus6.start = 1'b0;
    n = 0;
    while ((q6.size() != 0 || bus6.busy) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      errors++;
      checks++;
      $display("FAIL drain6: timeout, %0d twiddles outstanding", q6.size());
    end

    // N=8, stage 0 forward, with first-output latency
    push3(0, 1'b0);
    start3(0, 1'b0);
    check("busy_after_start", int'(bus3.busy), 1);
    n = 1;
    while (!bus3.rot_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency3", n, 3);
    drain3();

    // stage 1, stage 2, clamped stage 7, inverse stage 0
    for (int i = 0; i < 4; i++) begin
      push3(st_tab[i], iv_tab[i]);
      start3(st_tab[i], iv_tab[i]);
      drain3();
    end

    // alternating ready with a start pulse while busy
    push3(0, 1'b0);
    start3(0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      bus3.rot_ready = (i % 2 == 0);
      bus3.stage     = 4'd1;
      bus3.inv       = 1'b1;
      bus3.start     = (i == 4);
      if (i == 4) check("busy_at_ignored_start", int'(bus3.busy), 1);
      @(posedge clk); #1;
    end
    bus3.start     = 1'b0;
    bus3.rot_ready = 1'b1;
    drain3();

    // back-to-back: next start issued in the done cycle
    push3(1, 1'b0);
    start3(1, 1'b0);
    n = 0;
    while (!bus3.done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      errors++;
      checks++;
      $display("FAIL wait_done3: no done pulse within %0d cycles", n);
    end
    push3(0, 1'b1);
    start3(0, 1'b1);
    check("busy_back_to_back", int'(bus3.busy), 1);
    drain3();

    // reset on the second output cycle
    push3(0, 1'b0);
    start3(0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("second_out_real", int'($signed(bus3.rotator_real)), 46341);
    rst = 1'b0;
    #1;
    check("abort_valid", int'(bus3.rot_valid), 0);
    check("abort_last", int'(bus3.rot_last), 0);
    check("abort_busy", int'(bus3.busy), 0);
    check("abort_done", int'(bus3.done), 0);
    check("abort_real", int'($signed(bus3.rotator_real)), 0);
    check("abort_img", int'($signed(bus3.rotator_img)), 0);
    q3.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("no_stale_valid", int'(bus3.rot_valid), 0);
    end
    push3(0, 1'b0);
    start3(0, 1'b0);
    drain3();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
